// File: rtl/stack_ring.sv
// stack_ring: cached top-of-stack register over a 2^dep-entry register file.
// Capacity is 2^dep + 1 entries (TOS register included). With circ=1 the
// stack wraps silently on overflow/underflow; with circ=0 illegal pushes and
// pops are dropped and raise sticky ovf/unf flags.
module stack_ring #(
  parameter int dep  = 2,
  parameter int l    = 16,
  parameter int circ = 1
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         push,
  input  logic         pop,
  input  logic [l-1:0] in,
  input  logic         clr_err,
  output logic [l-1:0] tos,
  output logic [l-1:0] nos,
  output logic [dep:0] count,
  output logic         empty,
  output logic         full,
  output logic         ovf,
  output logic         unf
);

  localparam int unsigned depth   = 1 << dep;
  localparam logic [dep:0] cap    = (dep + 1)'(depth + 1);
  localparam bit           is_circ = (circ != 0);

  typedef enum logic [1:0] {
    cmd_idle = 2'b00,
    cmd_pop  = 2'b01,
    cmd_push = 2'b10,
    cmd_repl = 2'b11
  } cmd_t;

  logic [l-1:0]   mem [depth];
  logic [dep-1:0] sp;
  logic [dep-1:0] sp_inc;
  logic [dep-1:0] sp_dec;
  cmd_t           cmd;
  logic           at_full;
  logic           at_empty;
  logic           do_push;
  logic           do_pop;
  logic           do_repl;
  logic           ovf_set;
  logic           unf_set;

  assign cmd      = cmd_t'({push, pop});
  assign sp_inc   = sp + 1'b1;
  assign sp_dec   = sp - 1'b1;
  assign at_full  = (count == cap);
  assign at_empty = (count == '0);

  assign empty = at_empty;
  assign full  = at_full;
  assign nos   = mem[sp];

  // Decode the command into guarded actions and error events.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    do_push = 1'b0;
    do_pop  = 1'b0;
    do_repl = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    case (cmd)
      cmd_push: begin
        if (is_circ || !at_full) do_push = 1'b1;
        else                     ovf_set = 1'b1;
      end
      cmd_pop: begin
        if (is_circ || !at_empty) do_pop  = 1'b1;
        else                      unf_set = 1'b1;
      end
      cmd_repl: do_repl = 1'b1;
      default:  ;
    endcase
  end

  // Register file write: the old TOS spills into the slot above NOS.
  always_ff @(posedge clk) begin
    // NOTE: the register file has no reset so it can map onto distributed RAM.
    if (do_push) mem[sp_inc] <= tos;
  end

  // TOS register and stack pointer.
  always_ff @(posedge clk or negedge nreset) begin
    // NOTE: state registers use non-blocking assignments so all updates land together on the edge.
    if (!nreset) begin
      tos <= '0;
      sp  <= '0;
    end else if (do_push) begin
      tos <= in;
      sp  <= sp_inc;
    end else if (do_pop) begin
      tos <= mem[sp];
      sp  <= sp_dec;
    end else if (do_repl) begin
      tos <= in;
    end
  end

  // Entry counter, saturating at capacity and floored at zero.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      count <= '0;
    end else if (do_push) begin
      if (!at_full) count <= count + 1'b1;
    end else if (do_pop) begin
      if (!at_empty) count <= count - 1'b1;
    end
  end

  // Sticky error flags; a new error beats a simultaneous clear.
  // In circular mode the set terms are constant zero so the flags stay low.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (ovf_set)      ovf <= 1'b1;
      else if (clr_err) ovf <= 1'b0;
      if (unf_set)      unf <= 1'b1;
      else if (clr_err) unf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stack_ring.sv
// Bench for stack_ring: a bounded (circ=0) and a circular (circ=1) instance
// share one directed stimulus stream. A stack/ring model tracks both and is
// compared on every falling edge; literal expectations pin the model.
module tb_stack_ring;

  localparam int N = 5;  // capacity for dep=2
  localparam int R = 4;  // register-file entries

  logic        clk = 1'b0;
  logic        nreset;
  logic        push, pop, clr_err;
  logic [15:0] din;

  logic [15:0] d_tos   [2];
  logic [15:0] d_nos   [2];
  logic [2:0]  d_count [2];
  logic        d_empty [2];
  logic        d_full  [2];
  logic        d_ovf   [2];
  logic        d_unf   [2];

  always #5 clk = ~clk;

  stack_ring #(.dep(2), .l(16), .circ(0)) dut_b (
    .clk(clk), .nreset(nreset), .push(push), .pop(pop), .in(din),
    .clr_err(clr_err), .tos(d_tos[0]), .nos(d_nos[0]), .count(d_count[0]),
    .empty(d_empty[0]), .full(d_full[0]), .ovf(d_ovf[0]), .unf(d_unf[0])
  );

  stack_ring #(.dep(2), .l(16), .circ(1)) dut_c (
    .clk(clk), .nreset(nreset), .push(push), .pop(pop), .in(din),
    .clr_err(clr_err), .tos(d_tos[1]), .nos(d_nos[1]), .count(d_count[1]),
    .empty(d_empty[1]), .full(d_full[1]), .ovf(d_ovf[1]), .unf(d_unf[1])
  );

  // ---------------- model ----------------
  // ring[i][0] is the entry just below TOS; a push inserts the old TOS at the
  // front and drops the oldest; a pop rotates the front entry to the back.
  int          m_cnt    [2];
  logic [15:0] m_tos    [2];
  bit          m_tos_ok [2];
  logic [15:0] m_ring   [2][R];
  bit          m_ring_ok[2][R];
  bit          m_ovf    [2];
  bit          m_unf    [2];
  string       pfx      [2] = '{"bnd", "circ"};

  int  n_cmp = 0;
  int  n_bad = 0;
  bit  cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_tos[i] = '0; m_tos_ok[i] = 1'b1;
      m_ovf[i] = 1'b0; m_unf[i] = 1'b0;
      for (int k = 0; k < R; k++) m_ring_ok[i][k] = 1'b0;
    end
  endtask

  task automatic model_step(input int i, input bit p, input bit q, input logic [15:0] d, input bit c);
    logic [15:0] x;
    bit          xo;
    if (c && i == 0) begin m_ovf[i] = 1'b0; m_unf[i] = 1'b0; end
    if (p && q) begin
      m_tos[i] = d; m_tos_ok[i] = 1'b1;
    end else if (p) begin
      if (i == 0 && m_cnt[i] == N) m_ovf[i] = 1'b1;
      else begin
        for (int k = R - 1; k > 0; k--) begin
          m_ring[i][k] = m_ring[i][k-1]; m_ring_ok[i][k] = m_ring_ok[i][k-1];
        end
        m_ring[i][0] = m_tos[i]; m_ring_ok[i][0] = m_tos_ok[i];
        m_tos[i] = d; m_tos_ok[i] = 1'b1;
        if (m_cnt[i] < N) m_cnt[i]++;
      end
    end else if (q) begin
      if (i == 0 && m_cnt[i] == 0) m_unf[i] = 1'b1;
      else begin
        x = m_ring[i][0]; xo = m_ring_ok[i][0];
        for (int k = 0; k < R - 1; k++) begin
          m_ring[i][k] = m_ring[i][k+1]; m_ring_ok[i][k] = m_ring_ok[i][k+1];
        end
        m_ring[i][R-1] = x; m_ring_ok[i][R-1] = xo;
        m_tos[i] = x; m_tos_ok[i] = xo;
        if (m_cnt[i] > 0) m_cnt[i]--;
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      check({pfx[i], ".count"}, d_count[i], m_cnt[i]);
      check({pfx[i], ".empty"}, d_empty[i], m_cnt[i] == 0);
      check({pfx[i], ".full"},  d_full[i],  m_cnt[i] == N);
      check({pfx[i], ".ovf"},   d_ovf[i],   m_ovf[i]);
      check({pfx[i], ".unf"},   d_unf[i],   m_unf[i]);
      if (m_tos_ok[i]) check({pfx[i], ".tos"}, d_tos[i], m_tos[i]);
      if (m_cnt[i] >= 2 && m_ring_ok[i][0]) check({pfx[i], ".nos"}, d_nos[i], m_ring[i][0]);
    end
  endtask

  always @(negedge clk) if (cmp_en) compare_all();

  // One command cycle: drive, capture on posedge, step model, return at negedge.
  task automatic cmd(input bit p, input bit q, input logic [15:0] d, input bit c);
    push = p; pop = q; din = d; clr_err = c;
    @(posedge clk);
    model_step(0, p, q, d, c);
    model_step(1, p, q, d, c);
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < 2; i++) begin
      check({tag, pfx[i], ".tos"},   d_tos[i],   16'h0);
      check({tag, pfx[i], ".count"}, d_count[i], 0);
      check({tag, pfx[i], ".empty"}, d_empty[i], 1);
      check({tag, pfx[i], ".full"},  d_full[i],  0);
      check({tag, pfx[i], ".ovf"},   d_ovf[i],   0);
      check({tag, pfx[i], ".unf"},   d_unf[i],   0);
    end
  endtask

  initial begin
    nreset = 1'b0; push = 1'b0; pop = 1'b0; din = '0; clr_err = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_state("rst0.");
    nreset = 1'b1;
    cmp_en = 1'b1;

    // push/pop order
    cmd(1, 0, 16'h1111, 0);
    cmd(1, 0, 16'h2222, 0);
    cmd(1, 0, 16'h3333, 0);
    for (int i = 0; i < 2; i++) begin
      check({"lit.", pfx[i], ".tos3"}, d_tos[i], 16'h3333);
      check({"lit.", pfx[i], ".nos3"}, d_nos[i], 16'h2222);
      check({"lit.", pfx[i], ".cnt3"}, d_count[i], 3);
    end
    cmd(0, 1, 16'h0, 0);
    check("lit.bnd.pop1", d_tos[0], 16'h2222);
    cmd(0, 1, 16'h0, 0);
    check("lit.bnd.pop2", d_tos[0], 16'h1111);
    cmd(0, 1, 16'h0, 0);
    for (int i = 0; i < 2; i++) begin
      check({"lit.", pfx[i], ".pop3_tos"},   d_tos[i], 16'h0);
      check({"lit.", pfx[i], ".pop3_empty"}, d_empty[i], 1);
    end

    // pop at empty
    cmd(0, 1, 16'h0, 0);
    check("lit.bnd.unf", d_unf[0], 1);
    check("lit.bnd.unf_tos", d_tos[0], 16'h0);
    check("lit.bnd.unf_cnt", d_count[0], 0);
    check("lit.circ.unf", d_unf[1], 0);
    check("lit.circ.cnt0", d_count[1], 0);
    cmd(0, 0, 16'h0, 1);
    check("lit.bnd.unf_clr", d_unf[0], 0);

    // fill past capacity
    for (int v = 1; v <= 7; v++) cmd(1, 0, 16'(v), 0);
    check("lit.bnd.full_cnt", d_count[0], 5);
    check("lit.bnd.full",     d_full[0], 1);
    check("lit.bnd.full_tos", d_tos[0], 16'd5);
    check("lit.bnd.ovf",      d_ovf[0], 1);
    check("lit.circ.full_cnt", d_count[1], 5);
    check("lit.circ.full_tos", d_tos[1], 16'd7);
    check("lit.circ.ovf",      d_ovf[1], 0);

    // drain: circular cycles through the register file past empty
    for (int k = 0; k < 4; k++) begin
      cmd(0, 1, 16'h0, 0);
      check("lit.circ.drain_tos", d_tos[1], 16'(6 - k));
      check("lit.bnd.drain_tos",  d_tos[0], 16'(4 - k));
    end
    for (int k = 0; k < 6; k++) begin
      cmd(0, 1, 16'h0, 0);
      check("lit.circ.wrap_tos", d_tos[1], 16'(6 - (k % 4)));
      check("lit.circ.wrap_cnt", d_count[1], 0);
      check("lit.circ.wrap_unf", d_unf[1], 0);
    end
    check("lit.bnd.drain_unf", d_unf[0], 1);
    cmd(0, 0, 16'h0, 1);

    // overflow flag clear and clear-vs-new-error priority
    for (int k = 0; k < 8; k++) cmd(1, 0, 16'h0100 + 16'(k), 0);
    check("lit.bnd.ovf2", d_ovf[0], 1);
    cmd(0, 0, 16'h0, 1);
    check("lit.bnd.ovf_clr", d_ovf[0], 0);
    cmd(1, 0, 16'hDEAD, 1);
    check("lit.bnd.ovf_win", d_ovf[0], 1);
    check("lit.bnd.ovf_tos", d_tos[0], 16'h0104);
    check("lit.circ.push_full_tos", d_tos[1], 16'hDEAD);

    // asynchronous reset mid-sequence, with a push pending
    #2 nreset = 1'b0; push = 1'b1; din = 16'hFFFF;
    #1 check_reset_state("rst1.");
    model_reset();
    @(negedge clk);
    nreset = 1'b1; push = 1'b0;

    // replace
    cmd(1, 0, 16'hAAAA, 0);
    cmd(1, 1, 16'hBBBB, 0);
    for (int i = 0; i < 2; i++) begin
      check({"lit.", pfx[i], ".repl_tos"}, d_tos[i], 16'hBBBB);
      check({"lit.", pfx[i], ".repl_cnt"}, d_count[i], 1);
    end
    cmd(0, 1, 16'h0, 0);
    cmd(1, 1, 16'hCCCC, 0);
    for (int i = 0; i < 2; i++) begin
      check({"lit.", pfx[i], ".repl0_tos"}, d_tos[i], 16'hCCCC);
      check({"lit.", pfx[i], ".repl0_cnt"}, d_count[i], 0);
    end
    cmd(0, 0, 16'h0, 0);

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
